// File: rtl/candy_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : candy_sram_ctrl
//  Description : Single-word asynchronous SRAM controller for the candy core.
//                Sequences SETUP / ACCESS (WAIT_STATES cycles) / HOLD on the
//                SRAM bus, owns the data-pin tri-state, and returns read data
//                with a one-cycle ready pulse. All SRAM-side outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module candy_sram_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic              cpu_busy_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_data_io,
    output logic              chip_enable_o,
    output logic              write_enable_o,
    output logic              read_enable_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    // Counter runs WAIT_STATES-1 down to 0, one step per ACCESS cycle.
    localparam logic [3:0] c_cnt_load  = 4'(WAIT_STATES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_drive;
    logic              w_accept;
    logic              w_last;
    logic              w_we_nxt;

    assign w_accept = (r_state == c_st_idle) && cpu_req_i;
    assign w_last   = (r_cnt == 4'd0);
    // Direction of the transaction that will be in flight after this edge.
    assign w_we_nxt = w_accept ? cpu_we_i : r_we;

    // Write data only reaches the pins while a write transaction owns the bus.
    assign sram_data_io = r_drive ? r_wdata : {DATA_W{1'bz}};

    // Next-state decode for the access sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (cpu_req_i) w_state_nxt = c_st_setup;
            c_st_setup:  w_state_nxt = c_st_access;
            c_st_access: if (w_last) w_state_nxt = c_st_hold;
            c_st_hold:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // Latch the request on acceptance and count ACCESS cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= 4'd0;
        end else begin
            if (w_accept) begin
                r_we    <= cpu_we_i;
                r_wdata <= cpu_wdata_i;
            end
            if (r_state == c_st_setup) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == c_st_access) && !w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // State register plus bus outputs, decoded from the state being entered
    // so every pin changes on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            chip_enable_o  <= 1'b0;
            write_enable_o <= 1'b0;
            read_enable_o  <= 1'b0;
            cpu_ready_o    <= 1'b0;
            cpu_busy_o     <= 1'b0;
            r_drive        <= 1'b0;
            sram_addr_o    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            chip_enable_o  <= (w_state_nxt != c_st_idle);
            write_enable_o <= w_we_nxt && (w_state_nxt == c_st_access);
            read_enable_o  <= !w_we_nxt && ((w_state_nxt == c_st_setup) ||
                                            (w_state_nxt == c_st_access));
            cpu_ready_o    <= (w_state_nxt == c_st_hold);
            cpu_busy_o     <= (w_state_nxt != c_st_idle);
            r_drive        <= w_we_nxt && (w_state_nxt != c_st_idle);
            if (w_accept) begin
                sram_addr_o <= cpu_addr_i;
            end
        end
    end

    // Capture read data on the edge that leaves the final ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_o <= '0;
        end else if ((r_state == c_st_access) && w_last && !r_we) begin
            cpu_rdata_o <= sram_data_io;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_candy_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_candy_sram_ctrl
//  Description : Directed self-checking bench for candy_sram_ctrl. Two
//                instances (WAIT_STATES = 2 and 1), each on its own SRAM model
//                with a pulled-up data bus so a released bus reads all ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_candy_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        sel = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] rd_prev [2];

    wire [15:0] rdata0, rdata1, saddr0, saddr1;
    wire        ready0, ready1, busy0, busy1, ce0, ce1, wen0, wen1, oen0, oen1;
    tri1 [15:0] bus0;
    tri1 [15:0] bus1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    candy_sram_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .rst(rst), .cpu_req_i(req0), .cpu_we_i(we),
        .cpu_addr_i(addr), .cpu_wdata_i(wdata), .cpu_rdata_o(rdata0),
        .cpu_ready_o(ready0), .cpu_busy_o(busy0), .sram_addr_o(saddr0),
        .sram_data_io(bus0), .chip_enable_o(ce0), .write_enable_o(wen0),
        .read_enable_o(oen0)
    );

    candy_sram_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cpu_req_i(req1), .cpu_we_i(we),
        .cpu_addr_i(addr), .cpu_wdata_i(wdata), .cpu_rdata_o(rdata1),
        .cpu_ready_o(ready1), .cpu_busy_o(busy1), .sram_addr_o(saddr1),
        .sram_data_io(bus1), .chip_enable_o(ce1), .write_enable_o(wen1),
        .read_enable_o(oen1)
    );

    // SRAM models: drive on output-enable, store on write strobe.
    assign bus0 = (ce0 && oen0 && !wen0) ? mem0[saddr0[7:0]] : 16'hzzzz;
    assign bus1 = (ce1 && oen1 && !wen1) ? mem1[saddr1[7:0]] : 16'hzzzz;
    always @(posedge clk) if (ce0 && wen0) mem0[saddr0[7:0]] <= bus0;
    always @(posedge clk) if (ce1 && wen1) mem1[saddr1[7:0]] <= bus1;

    // View of whichever instance is under test.
    wire        m_ce    = sel ? ce1 : ce0;
    wire        m_we    = sel ? wen1 : wen0;
    wire        m_oe    = sel ? oen1 : oen0;
    wire        m_ready = sel ? ready1 : ready0;
    wire        m_busy  = sel ? busy1 : busy0;
    wire [15:0] m_addr  = sel ? saddr1 : saddr0;
    wire [15:0] m_bus   = sel ? bus1 : bus0;
    wire [15:0] m_rdata = sel ? rdata1 : rdata0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issues one transaction; entered and left at #1 after a rising edge.
    // Returns in the first IDLE cycle after HOLD.
    task automatic do_txn(input bit s, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input int ws, input bit keep,
                          input logic [15:0] exp_rd, output int rdy_cyc);
        int rdy_k, strobe, oe_n;
        bit bad_strobe, bad_rbus, overlap;
        logic [15:0] prev;
        prev = rd_prev[s];
        sel = s; we = w; addr = a; wdata = d;
        if (s) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
        // Scramble the inputs: the block must work from its latched copies.
        we = ~w; addr = ~a; wdata = ~d;
        rdy_k = -1; rdy_cyc = -1; strobe = 0; oe_n = 0;
        bad_strobe = 0; bad_rbus = 0; overlap = 0;
        for (int k = 0; k <= ws + 2; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (m_ready) begin rdy_k = (rdy_k < 0) ? k : 99; rdy_cyc = cyc; end
            if (m_we) begin
                strobe++;
                if (m_addr != a || m_bus != d || !m_ce) bad_strobe = 1;
            end
            if (m_oe) begin
                oe_n++;
                if (m_addr != a || m_bus != exp_rd || !m_ce) bad_rbus = 1;
            end
            if (m_we && m_oe) overlap = 1;
            if (k == 0) check("busy_setup", {31'd0, m_busy}, 32'd1);
            if (k <= ws) check("rdata_before", {16'd0, m_rdata}, {16'd0, prev});
            if (k == ws + 1) begin
                check("rdata_ready", {16'd0, m_rdata}, {16'd0, w ? prev : exp_rd});
                check("hold_bus", {16'd0, m_bus}, {16'd0, w ? d : 16'hFFFF});
                check("hold_ce", {31'd0, m_ce}, 32'd1);
            end
        end
        check("ready_latency", rdy_k, ws + 1);
        check("we_width", strobe, w ? ws : 0);
        check("oe_width", oe_n, w ? 0 : ws + 1);
        check("strobe_addr_data", {31'd0, bad_strobe}, 32'd0);
        check("read_addr_bus", {31'd0, bad_rbus}, 32'd0);
        check("we_oe_overlap", {31'd0, overlap}, 32'd0);
        check("idle_bus_z", {16'd0, m_bus}, 32'h0000FFFF);
        check("idle_busy", {31'd0, m_busy}, 32'd0);
        if (!w) rd_prev[s] = exp_rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int c1, c2;
        rd_prev[0] = 16'h0; rd_prev[1] = 16'h0;

        // Reset, released between edges, then 20 quiet cycles on both DUTs.
        #10 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("rst_ctl0", {27'd0, ce0, wen0, oen0, ready0, busy0}, 32'd0);
            check("rst_ctl1", {27'd0, ce1, wen1, oen1, ready1, busy1}, 32'd0);
            check("rst_bus", {bus1, bus0}, 32'hFFFF_FFFF);
            check("rst_rdata", {rdata1, rdata0}, 32'd0);
        end

        // WAIT_STATES = 2: write then read back.
        do_txn(0, 1, 16'h0012, 16'hBEEF, 2, 0, 16'h0000, c1);
        do_txn(0, 0, 16'h0012, 16'h0000, 2, 0, 16'hBEEF, c1);

        // Back-to-back with request held high.
        do_txn(0, 1, 16'h0001, 16'h1111, 2, 1, 16'h0000, c1);
        do_txn(0, 0, 16'h0001, 16'h0000, 2, 0, 16'h1111, c2);
        check("b2b_ready_gap", c2 - c1, 5);

        // Reset in the middle of a write's ACCESS phase.
        sel = 0; we = 1'b1; addr = 16'h0040; wdata = 16'h1234; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_we", {30'd0, m_we, m_ce}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_now_ctl", {29'd0, m_ce, m_we, m_busy}, 32'd0);
        check("rst_now_bus", {16'd0, m_bus}, 32'h0000FFFF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_no_ready", {31'd0, m_ready}, 32'd0);
        end
        #3 rst = 1'b0;
        rd_prev[0] = 16'h0; rd_prev[1] = 16'h0;
        @(posedge clk); #1;
        check("post_rst_ctl", {29'd0, m_ce, m_ready, m_busy}, 32'd0);
        check("post_rst_rdata", {16'd0, m_rdata}, 32'd0);
        do_txn(0, 0, 16'h0012, 16'h0000, 2, 0, 16'hBEEF, c1);

        // WAIT_STATES = 1 instance.
        do_txn(1, 1, 16'h0033, 16'hA5C3, 1, 0, 16'h0000, c1);
        do_txn(1, 0, 16'h0033, 16'h0000, 1, 0, 16'hA5C3, c1);
        do_txn(1, 1, 16'h0007, 16'h0F0E, 1, 0, 16'h0000, c1);
        check("ws1_rdata_kept", {16'd0, rdata1}, 32'h0000A5C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/candy_sram_ctrl.md
Name: candy_sram_ctrl

Overview:
- Memory-side stage directly downstream of the candy core's load/store path.
- Accepts single-word read/write requests from the core, sequences the external asynchronous SRAM bus, and returns read data with a one-cycle ready pulse.
- Sequencing covers address, chip/read/write enables, the bidirectional data pin, and a parameterised wait-state count.
- Owns the tri-state control of sram_data_io. All SRAM-side outputs are registered.

Parameters:
- ADDR_W, 16: SRAM word-address width.
- DATA_W, 16: SRAM/CPU data width. Matches the `SRAMDataWidth` define.
- WAIT_STATES, 2: number of ACCESS cycles. Legal range 1..15.

Ports:
- clk  in  1: system clock. All state updates on its rising edge.
- rst  in  1: asynchronous, active-high reset (`RstEnable` = 1).
- cpu_req_i  in  1: request valid. Sampled only in IDLE.
- cpu_we_i  in  1: 1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W: word address.
- cpu_wdata_i  in  DATA_W: write data.
- cpu_rdata_o  out  DATA_W: last read data. Registered; holds until the next read completes.
- cpu_ready_o  out  1: one-cycle completion pulse.
- cpu_busy_o  out  1: high whenever state != IDLE.
- sram_addr_o  out  ADDR_W: SRAM address.
- sram_data_io  inout  DATA_W: SRAM data bus. High-Z unless this block is driving a write.
- chip_enable_o  out  1: SRAM chip enable, asserted high.
- write_enable_o  out  1: SRAM write strobe, asserted high.
- read_enable_o  out  1: SRAM output enable, asserted high.

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - state = IDLE.
  - chip_enable_o = write_enable_o = read_enable_o = 0.
  - cpu_ready_o = 0, cpu_busy_o = 0.
  - sram_addr_o = 0, cpu_rdata_o = 0.
  - sram_data_io released to high-Z.
  - Any in-flight transaction is dropped; no ready pulse follows.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - All enables 0; bus high-Z.
  - At a rising edge with cpu_req_i = 1: latch addr, we and wdata into internal registers, then go to SETUP.
- SETUP (1 cycle):
  - sram_addr_o = latched addr; chip_enable_o = 1.
  - Read: read_enable_o = 1.
  - Write: sram_data_io driven with latched wdata; write_enable_o = 0 (address/data setup before the strobe).
- ACCESS (WAIT_STATES cycles, counted by an internal counter loaded in SETUP):
  - Read: chip_enable_o = read_enable_o = 1. At the edge leaving the last ACCESS cycle, capture sram_data_io into cpu_rdata_o.
  - Write: chip_enable_o = write_enable_o = 1; data still driven.
- HOLD (1 cycle):
  - chip_enable_o = 1; write_enable_o = read_enable_o = 0.
  - Write data is still driven (hold time).
  - cpu_ready_o = 1 for exactly this cycle.
  - Next state is IDLE.
- Latency: if the request is sampled at edge E0, cpu_ready_o is high in the cycle after edge E0 + WAIT_STATES + 1.
  - Total transaction occupancy is WAIT_STATES + 2 cycles.
  - Back-to-back requests therefore start every WAIT_STATES + 3 cycles.
- Request handshake:
  - cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i are ignored outside IDLE; the latched copies are used.
  - If cpu_req_i is still 1 in the IDLE cycle after HOLD, a new transaction is accepted (intended back-to-back mode).
- Write data is never driven onto sram_data_io during a read transaction or in IDLE. There is no cycle in which both write_enable_o and read_enable_o are 1.
- A read leaves cpu_rdata_o unchanged until its capture edge. A write never modifies cpu_rdata_o.
- Address wrap: none. The address passes through unmodified.

Test Plan:
- Reset hold, then release at 10 ns with no req → all enables 0, cpu_ready_o 0, sram_data_io = Z, cpu_rdata_o = 0 for 20 cycles.
- Write, addr 0x0012, data 0xBEEF, WAIT_STATES = 2:
  - ready pulse one cycle, 4 cycles after the sampling edge.
  - write_enable_o high for exactly 2 cycles, and only while addr = 0x0012 and bus = 0xBEEF.
  - Bus is Z again after HOLD.
- Read of addr 0x0012 from an SRAM model holding 0xBEEF:
  - read_enable_o high 3 cycles (SETUP + 2 ACCESS).
  - cpu_rdata_o = 0xBEEF in the ready cycle; bus never driven by the DUT.
- Back-to-back with req held high: write 0x0001 ← 0x1111, then read 0x0001:
  - the second transaction starts in the IDLE cycle after the first ready.
  - read returns 0x1111; ready pulses are separated by 5 cycles.
- Reset asserted in the middle of a write's ACCESS phase:
  - same cycle: write_enable_o/chip_enable_o drop to 0 and the bus goes Z; no ready pulse.
  - after release, a new read completes normally.
- WAIT_STATES = 1 build: read and write each complete with ready 3 cycles after the sampling edge; strobe width is 1 cycle.
